obs_grid: RTL and testbench
===========================

OBS_GRID -- requirements
Module: obs_grid

Interface
REQ-001 SHALL provide parameter COLS, default 8, obstacle columns (1..16).
REQ-002 SHALL provide parameter ROWS, default 2, obstacle rows (1..4); N = COLS*ROWS.
REQ-003 SHALL provide parameters X0=20, Y0=20: top-left pixel of cell (0,0).
REQ-004 SHALL provide parameters W=60, H=20: cell width/height in pixels.
REQ-005 SHALL provide parameters XPITCH=80, YPITCH=30: column/row pitch in pixels.
REQ-006 SHALL provide parameter RGB_ALIVE, default 3'b100, colour of a live cell.
REQ-007 SHALL provide parameters MARCH_DIV=4, frames per march step, and MARCH_RANGE=20, max horizontal offset.
REQ-008 clk  input  1  system clock; all state updates on rising edge.
REQ-009 reset  input  1  synchronous, active-low reset.
REQ-010 video_on  input  1  active display region.
REQ-011 pix_x, pix_y  input  11 each  current pixel coordinates.
REQ-012 frame_tick  input  1  one-cycle pulse, once per frame.
REQ-013 bull_x, bull_y  input  11 each  bullet tip coordinates.
REQ-014 bull_valid  input  1  bullet in flight.
REQ-015 restart  input  1  one-cycle pulse, start new round.
REQ-016 obs_on  output  1  current pixel lies in a live cell.
REQ-017 rgb  output  3  RGB_ALIVE when obs_on, else 3'b000.
REQ-018 alive  output  N  live bitmap, bit index = row*COLS + col.
REQ-019 hit  output  1  one-cycle pulse per destroyed cell.
REQ-020 hit_idx  output  max(1,ceil(log2 N))  index of last destroyed cell.
REQ-021 score  output  16  destroyed-cell count.
REQ-022 gamewin  output  1  high in WIN state.
REQ-023 off_x  output  11  current horizontal march offset.

Function
REQ-024 Cell (c,r) SHALL span x in [X0+c*XPITCH+off_x, X0+c*XPITCH+off_x+W), y in [Y0+r*YPITCH, Y0+r*YPITCH+H); bounds lower-inclusive, upper-exclusive.
REQ-025 obs_on, rgb SHALL be combinational from pix_x/pix_y/video_on/alive/off_x/state; obs_on=0 when video_on=0 or in WIN.
REQ-026 FSM SHALL have states PLAY and WIN; PLAY->WIN the cycle after alive becomes all-zero; WIN->PLAY on restart.
REQ-027 In PLAY, when bull_valid=1, armed=1, and bullet point lies in a live cell, that alive bit SHALL clear on the next edge, hit SHALL pulse 1 cycle, hit_idx SHALL load the index, armed SHALL clear.
REQ-028 armed SHALL re-set when bull_valid=0; one bullet flight destroys at most one cell.
REQ-029 If the bullet lies in multiple cells (overlapping parameters), the lowest index SHALL be taken.
REQ-030 Bullet in a dead cell or outside all cells SHALL produce no hit and leave armed unchanged.
REQ-031 score SHALL increment by 1 per hit, saturating at 16'hFFFF.
REQ-032 restart SHALL set alive to all ones, score to 0, off_x to 0, armed to 1, state PLAY, in any state; restart wins over a simultaneous hit (no hit pulse).
REQ-033 In WIN, alive, score, off_x SHALL hold; bullets ignored.

Reset
REQ-034 reset=0 at a clock edge SHALL force: alive all ones, score 0, hit 0, hit_idx 0, off_x 0, march direction right, frame counter 0, armed 1, state PLAY, gamewin 0.
REQ-035 Reset mid-operation SHALL abandon any pending hit; no hit pulse the following cycle.

Configuration
REQ-036 With OBS_GRID_MARCH_EN defined, off_x SHALL advance by 1 every MARCH_DIV frame_ticks in PLAY, counting up to MARCH_RANGE then down to 0, reversing at each bound (no overshoot); collision and rendering both use off_x.
REQ-037 Without OBS_GRID_MARCH_EN, off_x SHALL be constant 0 and no march counter SHALL exist.

Verification
REQ-038 Reset, then bull_valid=1 at (25,25) -> next cycle hit=1, hit_idx=0, alive=16'hFFFE, score=1.
REQ-039 Hold bullet at (25,25) then move to (105,25) without dropping bull_valid -> no second hit; drop bull_valid 1 cycle, reassert at (105,25) -> hit, hit_idx=1.
REQ-040 Bullet at (80,25) (gap, x=X0+W) -> no hit; at (79,39) -> hit idx 0.
REQ-041 Destroy all 16 cells -> gamewin=1 one cycle after last hit, score=16, obs_on=0 everywhere; restart -> alive=16'hFFFF, score=0, gamewin=0.
REQ-042 restart and valid hit same cycle -> alive all ones, score 0, hit=0.
REQ-043 With OBS_GRID_MARCH_EN, 84 frame_ticks -> off_x=20 after 80, then 19 after 84; pixel (20,20) obs_on=0 while off_x>0.

Source files
------------

// File: rtl/obs_grid_if.sv
// obs_grid_if: video, bullet and status signals of the obstacle grid.
// master = game/video side driving pixels and bullets, slave = obs_grid.
interface obs_grid_if #(
    parameter int N  = 16,
    parameter int IW = 4
);
    logic          video_on;
    logic [10:0]   pix_x;
    logic [10:0]   pix_y;
    logic          frame_tick;
    logic [10:0]   bull_x;
    logic [10:0]   bull_y;
    logic          bull_valid;
    logic          restart;
    logic          obs_on;
    logic [2:0]    rgb;
    logic [N-1:0]  alive;
    logic          hit;
    logic [IW-1:0] hit_idx;
    logic [15:0]   score;
    logic          gamewin;
    logic [10:0]   off_x;

    modport master (
        output video_on, pix_x, pix_y, frame_tick,
        output bull_x, bull_y, bull_valid, restart,
        input  obs_on, rgb, alive, hit, hit_idx, score, gamewin, off_x
    );

    modport slave (
        input  video_on, pix_x, pix_y, frame_tick,
        input  bull_x, bull_y, bull_valid, restart,
        output obs_on, rgb, alive, hit, hit_idx, score, gamewin, off_x
    );
endinterface

// File: rtl/obs_grid.sv
// obs_grid: grid of destructible obstacle cells. Renders live cells,
// destroys the lowest-indexed live cell under a bullet (once per flight),
// keeps score and flags a win when every cell is gone.
// Optional OBS_GRID_MARCH_EN: grid marches horizontally, one pixel every
// MARCH_DIV frames, bouncing between offsets 0 and MARCH_RANGE.
module obs_grid #(
    parameter int       COLS        = 8,
    parameter int       ROWS        = 2,
    parameter int       X0          = 20,
    parameter int       Y0          = 20,
    parameter int       W           = 60,
    parameter int       H           = 20,
    parameter int       XPITCH      = 80,
    parameter int       YPITCH      = 30,
    parameter bit [2:0] RGB_ALIVE   = 3'b100,
    parameter int       MARCH_DIV   = 4,
    parameter int       MARCH_RANGE = 20
) (
    input  logic      clk,
    input  logic      reset,
    obs_grid_if.slave bus
);
    localparam int N  = COLS * ROWS;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {PLAY, WIN} state_t;

    state_t        state, state_nxt;
    logic          play;
    logic [N-1:0]  alive_q;
    logic [15:0]   score_q;
    logic          hit_q;
    logic [IW-1:0] hit_idx_q;
    logic          armed_q;
    logic [10:0]   off_x;

    logic [N-1:0]  pix_in;
    logic [N-1:0]  bul_in;
    logic          bul_any;
    logic [IW-1:0] bul_idx;
    int            xl, yl;

    // Cell membership of the current pixel and of the bullet tip, using the
    // same marched geometry for both so what you see is what you hit.
    always_comb begin
        pix_in = '0;
        bul_in = '0;
        xl     = 0;
        yl     = 0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                xl = X0 + c * XPITCH + int'(off_x);
                yl = Y0 + r * YPITCH;
                pix_in[r*COLS+c] = (int'(bus.pix_x) >= xl) && (int'(bus.pix_x) < xl + W) &&
                                   (int'(bus.pix_y) >= yl) && (int'(bus.pix_y) < yl + H);
                bul_in[r*COLS+c] = (int'(bus.bull_x) >= xl) && (int'(bus.bull_x) < xl + W) &&
                                   (int'(bus.bull_y) >= yl) && (int'(bus.bull_y) < yl + H);
            end
        end
    end

    // Lowest-index live cell under the bullet: scan downwards so the last
    // assignment is the smallest index when cells overlap.
    always_comb begin
        bul_any = 1'b0;
        bul_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (bul_in[i] && alive_q[i]) begin
                bul_any = 1'b1;
                bul_idx = IW'(i);
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset) state <= PLAY;
        else        state <= state_nxt;
    end

    // FSM next state: win one cycle after the grid empties, restart always returns to play.
    always_comb begin
        state_nxt = state;
        case (state)
            PLAY:    if (~|alive_q) state_nxt = WIN;
            WIN:     state_nxt = WIN;
            default: state_nxt = PLAY;
        endcase
        if (bus.restart) state_nxt = PLAY;
    end

    // FSM outputs.
    always_comb begin
        play        = (state == PLAY);
        bus.gamewin = (state == WIN);
    end

    // Alive bitmap, scoring and hit pulse; restart beats a same-cycle hit.
    always_ff @(posedge clk) begin
        if (!reset) begin
            alive_q   <= '1;
            score_q   <= '0;
            hit_q     <= 1'b0;
            hit_idx_q <= '0;
            armed_q   <= 1'b1;
        end else if (bus.restart) begin
            alive_q <= '1;
            score_q <= '0;
            hit_q   <= 1'b0;
            armed_q <= 1'b1;
        end else begin
            hit_q <= 1'b0;
            if (play) begin
                if (!bus.bull_valid) begin
                    armed_q <= 1'b1;
                end else if (armed_q && bul_any) begin
                    alive_q[bul_idx] <= 1'b0;
                    hit_q            <= 1'b1;
                    hit_idx_q        <= bul_idx;
                    armed_q          <= 1'b0;
                    if (score_q != 16'hFFFF) score_q <= score_q + 16'd1;
                end
            end
        end
    end

`ifdef OBS_GRID_MARCH_EN
    localparam int FW = (MARCH_DIV > 1) ? $clog2(MARCH_DIV) : 1;

    logic [FW-1:0] frame_cnt;
    logic          dir_right;
    logic [10:0]   off_q;

    // March: one step every MARCH_DIV frames while playing, bouncing at 0 and MARCH_RANGE.
    always_ff @(posedge clk) begin
        if (!reset || bus.restart) begin
            frame_cnt <= '0;
            dir_right <= 1'b1;
            off_q     <= '0;
        end else if (play && bus.frame_tick) begin
            if (frame_cnt == FW'(MARCH_DIV - 1)) begin
                frame_cnt <= '0;
                if (dir_right) begin
                    if (off_q >= 11'(MARCH_RANGE)) begin
                        dir_right <= 1'b0;
                        off_q     <= off_q - 11'd1;
                    end else begin
                        off_q <= off_q + 11'd1;
                    end
                end else begin
                    if (off_q == 11'd0) begin
                        dir_right <= 1'b1;
                        off_q     <= off_q + 11'd1;
                    end else begin
                        off_q <= off_q - 11'd1;
                    end
                end
            end else begin
                frame_cnt <= frame_cnt + FW'(1);
            end
        end
    end

    assign off_x = off_q;
`else
    assign off_x = '0;
`endif

    // Pixel renderer: live cell under the beam, blanked outside video and after a win.
    always_comb begin
        bus.obs_on = bus.video_on && play && |(pix_in & alive_q);
        bus.rgb    = bus.obs_on ? RGB_ALIVE : 3'b000;
    end

    assign bus.alive   = alive_q;
    assign bus.hit     = hit_q;
    assign bus.hit_idx = hit_idx_q;
    assign bus.score   = score_q;
    assign bus.off_x   = off_x;
endmodule

// File: tb/tb_obs_grid.sv
// tb_obs_grid: scoreboard bench for obs_grid with default geometry
// (8x2 cells, 60x20 px, pitch 80x30, origin 20,20).
module tb_obs_grid;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    obs_grid_if #(.N(16), .IW(4)) bus ();
    obs_grid dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        logic        hit;
        logic [3:0]  idx;
        logic [15:0] alive;
        logic [15:0] score;
        logic        win;
    } exp_t;

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] m_alive;
    logic [15:0] m_score;
    logic [3:0]  m_idx;
    logic        m_armed;
    logic        m_win;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic int cell_at(input int x, input int y, input logic [15:0] a);
        for (int i = 0; i < 16; i++) begin
            int xl, yl;
            xl = 20 + (i % 8) * 80;
            yl = 20 + (i / 8) * 30;
            if (a[i] && x >= xl && x < xl + 60 && y >= yl && y < yl + 20) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_alive = 16'hFFFF;
        m_score = 16'd0;
        m_idx   = 4'd0;
        m_armed = 1'b1;
        m_win   = 1'b0;
    endtask

    // Drive one cycle of bullet/restart, push the expectation, then pop and compare.
    task automatic drive(input int x, input int y, input logic v, input logic rs);
        exp_t e;
        int   k;
        logic nxt_win;
        bus.bull_x     = 11'(x);
        bus.bull_y     = 11'(y);
        bus.bull_valid = v;
        bus.restart    = rs;
        k       = cell_at(x, y, m_alive);
        nxt_win = rs ? 1'b0 : (m_win || (m_alive == 16'd0));
        e.hit   = 1'b0;
        if (rs) begin
            m_alive = 16'hFFFF;
            m_score = 16'd0;
            m_armed = 1'b1;
        end else if (!m_win) begin
            if (!v) m_armed = 1'b1;
            else if (m_armed && k >= 0) begin
                e.hit      = 1'b1;
                m_alive[k] = 1'b0;
                m_idx      = 4'(k);
                m_armed    = 1'b0;
                if (m_score != 16'hFFFF) m_score = m_score + 16'd1;
            end
        end
        m_win   = nxt_win;
        e.idx   = m_idx;
        e.alive = m_alive;
        e.score = m_score;
        e.win   = m_win;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        bus.restart = 1'b0;
        e = sb.pop_front();
        chk("hit",     32'(bus.hit),     32'(e.hit));
        chk("hit_idx", 32'(bus.hit_idx), 32'(e.idx));
        chk("alive",   32'(bus.alive),   32'(e.alive));
        chk("score",   32'(bus.score),   32'(e.score));
        chk("gamewin", 32'(bus.gamewin), 32'(e.win));
    endtask

    task automatic pix(input string tag, input int x, input int y, input logic von, input logic exp);
        bus.pix_x    = 11'(x);
        bus.pix_y    = 11'(y);
        bus.video_on = von;
        #1;
        chk(tag, 32'(bus.obs_on), 32'(exp));
        chk({tag, "_rgb"}, 32'(bus.rgb), exp ? 32'd4 : 32'd0);
    endtask

    task automatic ticks(input int n);
        bus.bull_valid = 1'b0;
        m_armed        = 1'b1;
        bus.frame_tick = 1'b1;
        repeat (n) @(posedge clk);
        @(negedge clk);
        bus.frame_tick = 1'b0;
    endtask

    initial begin
        reset          = 1'b0;
        bus.video_on   = 1'b0;
        bus.pix_x      = '0;
        bus.pix_y      = '0;
        bus.frame_tick = 1'b0;
        bus.bull_x     = '0;
        bus.bull_y     = '0;
        bus.bull_valid = 1'b0;
        bus.restart    = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_alive", 32'(bus.alive),   32'hFFFF);
        chk("rst_score", 32'(bus.score),   32'd0);
        chk("rst_hit",   32'(bus.hit),     32'd0);
        chk("rst_idx",   32'(bus.hit_idx), 32'd0);
        chk("rst_offx",  32'(bus.off_x),   32'd0);
        chk("rst_win",   32'(bus.gamewin), 32'd0);
        reset = 1'b1;

        // First shot, then held bullet cannot score twice until re-armed.
        drive(25, 25, 1'b1, 1'b0);
        chk("first_alive", 32'(bus.alive), 32'hFFFE);
        drive(25, 25, 1'b1, 1'b0);
        drive(105, 25, 1'b1, 1'b0);
        drive(105, 25, 1'b0, 1'b0);
        drive(105, 25, 1'b1, 1'b0);
        chk("second_idx", 32'(bus.hit_idx), 32'd1);

        // Boundaries: x=X0+W is a gap, (79,39) is the last pixel of cell 0.
        drive(0, 0, 1'b0, 1'b1);
        drive(80, 25, 1'b1, 1'b0);
        drive(79, 39, 1'b1, 1'b0);
        drive(0, 0, 1'b0, 1'b1);

        // Rendering edges.
        pix("pix_tl",    20, 20, 1'b1, 1'b1);
        pix("pix_xgap",  80, 20, 1'b1, 1'b0);
        pix("pix_br",    79, 39, 1'b1, 1'b1);
        pix("pix_ygap",  79, 40, 1'b1, 1'b0);
        pix("pix_row1",  20, 50, 1'b1, 1'b1);
        pix("pix_row1y", 20, 49, 1'b1, 1'b0);
        pix("pix_voff",  20, 20, 1'b0, 1'b0);

        // Clear the whole grid, then win, blanking and restart.
        for (int i = 0; i < 16; i++) begin
            drive(0, 0, 1'b0, 1'b0);
            drive(25 + (i % 8) * 80, 25 + (i / 8) * 30, 1'b1, 1'b0);
        end
        drive(0, 0, 1'b0, 1'b0);
        chk("win_flag",  32'(bus.gamewin), 32'd1);
        chk("win_score", 32'(bus.score),   32'd16);
        pix("win_blank", 25, 25, 1'b1, 1'b0);
        drive(25, 25, 1'b1, 1'b0);
        drive(0, 0, 1'b0, 1'b1);
        chk("restart_alive", 32'(bus.alive), 32'hFFFF);

        // Restart wins over a simultaneous hit.
        drive(25, 25, 1'b1, 1'b0);
        drive(0, 0, 1'b0, 1'b0);
        drive(105, 25, 1'b1, 1'b1);
        chk("rs_hit", 32'(bus.hit), 32'd0);

        // Reset mid-flight with a bullet on a live cell: no pulse follows.
        drive(0, 0, 1'b0, 1'b0);
        drive(185, 25, 1'b1, 1'b0);
        bus.bull_x = 11'd265;
        reset      = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        bus.bull_valid = 1'b0;
        model_reset();
        chk("midrst_hit",   32'(bus.hit),   32'd0);
        chk("midrst_alive", 32'(bus.alive), 32'hFFFF);
        chk("midrst_score", 32'(bus.score), 32'd0);
        drive(0, 0, 1'b0, 1'b0);

`ifdef OBS_GRID_MARCH_EN
        ticks(4);
        chk("march_1", 32'(bus.off_x), 32'd1);
        ticks(76);
        chk("march_80", 32'(bus.off_x), 32'd20);
        pix("march_left", 20, 20, 1'b1, 1'b0);
        pix("march_in",   40, 20, 1'b1, 1'b1);
        ticks(4);
        chk("march_84", 32'(bus.off_x), 32'd19);
        drive(0, 0, 1'b0, 1'b1);
        chk("march_rs", 32'(bus.off_x), 32'd0);
`else
        ticks(8);
        chk("no_march", 32'(bus.off_x), 32'd0);
        pix("no_march_pix", 20, 20, 1'b1, 1'b1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
